round_shift_engine: RTL and testbench

//  Next-generation round block for the sparse polynomial multiplier. Accepts dense

---
 rtl/round_pkg.sv | 17 +
 rtl/round_funnel_shift.sv | 29 ++
 rtl/round_shift_engine.sv | 188 ++++++++++++++++++
 tb/tb_round_shift_engine.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/round_pkg.sv
// Shared types and helpers for the round shift engine.
//  - state_e    : operation sequencer states (IDLE / PAD / OUT)
//  - clamp_diff : saturates a shift amount to a maximum value
package round_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PAD  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Saturate diff to max_v; both operands are zero-extended to 32 bits by the caller.
  function automatic logic [31:0] clamp_diff(input logic [31:0] diff, input logic [31:0] max_v);
    return (diff > max_v) ? max_v : diff;
  endfunction

endpackage

// File: rtl/round_funnel_shift.sv
// Combinational funnel shifter over the concatenation {a,b}.
//  a, b : WORD_WIDTH-bit high / low words
//  d    : shift amount, 0..WORD_WIDTH
//  fl   : upper word of ({a,b} << d)
//  fr   : lower word of ({a,b} >> d)
module round_funnel_shift
  import round_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned DIFF_W     = 6
) (
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  input  logic [DIFF_W-1:0]     d,
  output logic [WORD_WIDTH-1:0] fl,
  output logic [WORD_WIDTH-1:0] fr
);

  localparam int unsigned CAT_W = 2 * WORD_WIDTH;

  logic [CAT_W-1:0] cat;

  always_comb begin
    cat = {a, b};
    fl  = WORD_WIDTH'((cat << d) >> WORD_WIDTH);
    fr  = WORD_WIDTH'(cat >> d);
  end

endmodule

// File: rtl/round_shift_engine.sv
// Round shift engine: keeps a 3-word history (cur, prev, prev2) of streamed
// normal words and funnel-shifts it by the sparse index difference, with a
// programmable dummy-cycle pad per operation.
//  in_valid/in_ready/in_word/in_only_add/in_diff/in_dummy : operation input
//  flush                                                   : clear history (IDLE only)
//  out_valid/out_ready/out_{high,low}_{left,right}         : registered result
//  busy, diff_err                                          : status (diff_err sticky)
// Build option: ROUND_CT_PAD_EN forces every op (only_add included) to take
// 1+MAX_DUMMY cycles regardless of in_dummy.
module round_shift_engine
  import round_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned DIFF_W     = 6,
  parameter int unsigned DUMMY_W    = 4,
  parameter int unsigned MAX_DUMMY  = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_word,
  input  logic                  in_only_add,
  input  logic [DIFF_W-1:0]     in_diff,
  input  logic [DUMMY_W-1:0]    in_dummy,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_high_left,
  output logic [WORD_WIDTH-1:0] out_high_right,
  output logic [WORD_WIDTH-1:0] out_low_left,
  output logic [WORD_WIDTH-1:0] out_low_right,
  output logic                  busy,
  output logic                  diff_err
);

  localparam logic [DUMMY_W-1:0] MAX_PAD = DUMMY_W'(MAX_DUMMY);

  state_e                 state_q, state_d;
  logic [DUMMY_W-1:0]     cnt_q, cnt_d;
  logic                   add_op_q, add_op_d;
  logic [WORD_WIDTH-1:0]  cur_q, cur_d, prev_q, prev_d, prev2_q, prev2_d;
  logic [WORD_WIDTH-1:0]  hl_q, hl_d, hr_q, hr_d, ll_q, ll_d, lr_q, lr_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   diff_err_q, diff_err_d;

  logic [DIFF_W-1:0]      d_clamp;
  logic                   diff_over;
  logic [DUMMY_W-1:0]     pad_len;
  logic                   add_pads;
  logic [WORD_WIDTH-1:0]  fl_hi, fr_hi, fl_lo, fr_lo;

  // Pad length and whether only_add ops also walk the pad.
`ifdef ROUND_CT_PAD_EN
  logic unused_dummy;
  assign unused_dummy = ^in_dummy;
  assign pad_len      = MAX_PAD;
  assign add_pads     = 1'b1;
`else
  assign pad_len      = (in_dummy > MAX_PAD) ? MAX_PAD : in_dummy;
  assign add_pads     = 1'b0;
`endif

  assign diff_over = 32'(in_diff) > 32'(WORD_WIDTH);
  assign d_clamp   = DIFF_W'(clamp_diff(32'(in_diff), 32'(WORD_WIDTH)));
  assign in_ready  = (state_q == IDLE) && !flush;

  // Shifters see the post-shift history of an accept: (in_word,cur) and (cur,prev).
  round_funnel_shift #(.WORD_WIDTH(WORD_WIDTH), .DIFF_W(DIFF_W)) u_fs_high (
    .a (in_word), .b (cur_q), .d (d_clamp), .fl (fl_hi), .fr (fr_hi)
  );

  round_funnel_shift #(.WORD_WIDTH(WORD_WIDTH), .DIFF_W(DIFF_W)) u_fs_low (
    .a (cur_q), .b (prev_q), .d (d_clamp), .fl (fl_lo), .fr (fr_lo)
  );

  // Sequencer, history and result next-state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_op_d    = add_op_q;
    cur_d       = cur_q;
    prev_d      = prev_q;
    prev2_d     = prev2_q;
    hl_d        = hl_q;
    hr_d        = hr_q;
    ll_d        = ll_q;
    lr_d        = lr_q;
    out_valid_d = out_valid_q;
    diff_err_d  = diff_err_q;

    unique case (state_q)
      IDLE: begin
        if (flush) begin
          cur_d   = '0;
          prev_d  = '0;
          prev2_d = '0;
        end else if (in_valid) begin
          prev2_d = prev_q;
          prev_d  = cur_q;
          cur_d   = in_word;
          if (!in_only_add) begin
            hl_d       = fl_hi;
            hr_d       = fr_hi;
            ll_d       = fl_lo;
            lr_d       = fr_lo;
            diff_err_d = diff_err_q | diff_over;
            add_op_d   = 1'b0;
            if (pad_len == '0) begin
              state_d     = OUT;
              out_valid_d = 1'b1;
            end else begin
              state_d = PAD;
              cnt_d   = pad_len - DUMMY_W'(1);
            end
          end else if (add_pads && (pad_len != '0)) begin
            state_d  = PAD;
            cnt_d    = pad_len - DUMMY_W'(1);
            add_op_d = 1'b1;
          end
        end
      end
      PAD: begin
        if (cnt_q == '0) begin
          if (add_op_q) begin
            state_d = IDLE;
          end else begin
            state_d     = OUT;
            out_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DUMMY_W'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      add_op_q    <= 1'b0;
      cur_q       <= '0;
      prev_q      <= '0;
      prev2_q     <= '0;
      hl_q        <= '0;
      hr_q        <= '0;
      ll_q        <= '0;
      lr_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      diff_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_op_q    <= add_op_d;
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      prev2_q     <= prev2_d;
      hl_q        <= hl_d;
      hr_q        <= hr_d;
      ll_q        <= ll_d;
      lr_q        <= lr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      diff_err_q  <= diff_err_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_high_left  = hl_q;
  assign out_high_right = hr_q;
  assign out_low_left   = ll_q;
  assign out_low_right  = lr_q;
  assign busy           = busy_q;
  assign diff_err       = diff_err_q;

endmodule

// File: tb/tb_round_shift_engine.sv
// Self-checking bench for round_shift_engine: directed scenarios plus a
// randomized op stream compared against a word-level history model.
module tb_round_shift_engine;

`ifdef ROUND_CT_PAD_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif
  localparam int MAXD = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = '0;
  logic        in_only_add = 1'b0;
  logic [5:0]  in_diff = '0;
  logic [3:0]  in_dummy = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_high_left, out_high_right, out_low_left, out_low_right;
  logic        busy, diff_err;

  round_shift_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .in_only_add(in_only_add), .in_diff(in_diff),
    .in_dummy(in_dummy), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_high_left(out_high_left),
    .out_high_right(out_high_right), .out_low_left(out_low_left),
    .out_low_right(out_low_right), .busy(busy), .diff_err(diff_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: word history, last result and sticky error.
  logic [31:0] m_cur = '0, m_prev = '0, m_prev2 = '0;
  logic [31:0] e_hl = '0, e_hr = '0, e_ll = '0, e_lr = '0;
  logic        e_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_fl(input logic [31:0] a, input logic [31:0] b, input int d);
    logic [63:0] x;
    x = {a, b} << d;
    return x[63:32];
  endfunction

  function automatic logic [31:0] m_fr(input logic [31:0] a, input logic [31:0] b, input int d);
    logic [63:0] x;
    x = {a, b} >> d;
    return x[31:0];
  endfunction

  function automatic void m_push(input logic [31:0] w);
    m_prev2 = m_prev;
    m_prev  = m_cur;
    m_cur   = w;
  endfunction

  function automatic void m_reset();
    m_cur = '0; m_prev = '0; m_prev2 = '0;
    e_hl = '0; e_hr = '0; e_ll = '0; e_lr = '0;
    e_err = 1'b0;
  endfunction

  task automatic check_outs(input string tag);
    check({tag, "_hl"}, out_high_left, e_hl);
    check({tag, "_hr"}, out_high_right, e_hr);
    check({tag, "_ll"}, out_low_left, e_ll);
    check({tag, "_lr"}, out_low_right, e_lr);
    check({tag, "_err"}, 32'(diff_err), 32'(e_err));
  endtask

  // One operation, entered and left just after a falling edge.
  task automatic do_op(input logic [31:0] w, input bit add, input int diff, input int dummy,
                       input int hold, input bit present, input logic [31:0] pw);
    int cyc;
    int lat;
    int d;
    bit saw_valid;
    cyc = 0;
    while (!in_ready && cyc < 64) begin @(negedge clk); cyc++; end
    check("ready_before_op", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_word = w; in_only_add = add;
    in_diff = 6'(diff); in_dummy = 4'(dummy);
    @(posedge clk);
    m_push(w);
    if (!add) begin
      d = (diff > 32) ? 32 : diff;
      if (diff > 32) e_err = 1'b1;
      e_hl = m_fl(m_cur, m_prev, d);
      e_hr = m_fr(m_cur, m_prev, d);
      e_ll = m_fl(m_prev, m_prev2, d);
      e_lr = m_fr(m_prev, m_prev2, d);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (add) begin
      lat = 1 + (CT ? MAXD : 0);
      cyc = 1;
      saw_valid = out_valid;
      while (!in_ready && cyc < 64) begin
        @(negedge clk); cyc++;
        saw_valid |= out_valid;
      end
      check("add_ready_cycle", 32'(cyc), 32'(lat));
      check("add_no_valid", 32'(saw_valid), 32'd0);
      check_outs("add_keep");
    end else begin
      lat = 1 + (CT ? MAXD : ((dummy > MAXD) ? MAXD : dummy));
      check("busy_c1", 32'(busy), 32'd1);
      cyc = 1;
      while (!out_valid && cyc < 64) begin @(negedge clk); cyc++; end
      check("latency", 32'(cyc), 32'(lat));
      check("busy_at_valid", 32'(busy), 32'd1);
      check_outs("result");
      for (int h = 0; h < hold; h++) begin
        if (present) begin
          in_valid = 1'b1; in_only_add = 1'b1; in_word = pw;
        end
        @(negedge clk);
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_not_ready", 32'(in_ready), 32'd0);
        check("hold_hl", out_high_left, e_hl);
        check("hold_lr", out_low_right, e_lr);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_hs_valid", 32'(out_valid), 32'd0);
      check("post_hs_ready", 32'(in_ready), 32'd1);
      if (present && hold > 0) begin
        @(posedge clk);
        m_push(pw);
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check_outs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: first-word load, d=0 pass-through.
    do_op(32'hF601589C, 1'b1, 0, 0, 0, 1'b0, '0);
    do_op(32'h33FACE1B, 1'b0, 0, 0, 0, 1'b0, '0);
    check("t1_hl", out_high_left, 32'h33FACE1B);
    check("t1_hr", out_high_right, 32'hF601589C);
    check("t1_lr", out_low_right, 32'h0);

    // Directed: d=4 across the word boundary.
    do_op(32'hF0000000, 1'b1, 0, 0, 0, 1'b0, '0);
    do_op(32'h0000000F, 1'b0, 4, 0, 0, 1'b0, '0);
    check("t2_hl", out_high_left, 32'h000000FF);
    check("t2_hr", out_high_right, 32'hFF000000);

    // Directed: pad of 5, then backpressure with a word presented.
    do_op(32'h12345678, 1'b0, 7, 5, 0, 1'b0, '0);
    do_op(32'h9ABCDEF0, 1'b0, 13, 2, 3, 1'b1, 32'hA5A5A5A5);
    do_op(32'h0F0F0F0F, 1'b0, 0, 0, 0, 1'b0, '0);
    check("t4_presented", out_high_right, 32'hA5A5A5A5);

    // Directed: over-range diff clamps and sticks.
    do_op(32'hCAFEBABE, 1'b0, 40, 1, 0, 1'b0, '0);
    check("t5_hl_prev", out_high_left, 32'h0F0F0F0F);
    check("t5_hr_cur", out_high_right, 32'hCAFEBABE);
    do_op(32'h13579BDF, 1'b0, 3, 0, 1, 1'b0, '0);
    check("t5_sticky", 32'(diff_err), 32'd1);

    // Randomized op stream.
    for (int i = 0; i < 40; i++) begin
      int df;
      df = ($urandom % 8 == 0) ? 33 + int'($urandom % 31) : int'($urandom % 33);
      do_op($urandom, ($urandom % 4) == 0, df, int'($urandom % 7), int'($urandom % 3),
            bit'($urandom % 2), $urandom);
    end

    // Reset while padding discards the pending op.
    in_valid = 1'b1; in_word = 32'h55AA55AA; in_only_add = 1'b0;
    in_diff = 6'd5; in_dummy = 4'd8;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_reset();
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check_outs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Flush beats a simultaneous valid and clears history.
    do_op(32'h11111111, 1'b1, 0, 0, 0, 1'b0, '0);
    do_op(32'h22222222, 1'b1, 0, 0, 0, 1'b0, '0);
    flush = 1'b1; in_valid = 1'b1; in_only_add = 1'b1; in_word = 32'h33333333;
    #1;
    check("flush_not_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    m_cur = '0; m_prev = '0; m_prev2 = '0;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    do_op(32'h44444444, 1'b0, 0, 0, 0, 1'b0, '0);
    check("flush_hr", out_high_right, 32'h0);
    check("flush_ll", out_low_left, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
